tone_detect_bank: RTL and testbench
===================================

TONE_DETECT_BANK -- requirements
Module: tone_detect_bank

Interface
REQ-001 SHALL have parameter N_CH, default 6: number of tone channels (1..16).
REQ-002 SHALL have parameter MAG_W, default 16: signed magnitude and threshold width.
REQ-003 SHALL have parameter CNT_W, default 8: run-length counter and bits_thd width.
REQ-004 SHALL have parameters DEF_THD (default 300) and DEF_BITS (default 10): per-channel reset values of thd_lev and bits_thd.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port clk_enable, input, 1: global advance enable.
REQ-008 SHALL have port mag_in, input, MAG_W: signed filter-energy sample.
REQ-009 SHALL have port mag_ch, input, clog2(N_CH): channel index of mag_in.
REQ-010 SHALL have port mag_valid, input, 1: sample strobe.
REQ-011 SHALL have ports cfg_we (input, 1), cfg_addr (input, 5) and cfg_wdata (input, MAG_W): register write port.
REQ-012 SHALL have port det_out, output, N_CH: per-channel tone-present flags.
REQ-013 SHALL have port det_chg, output, 1: one-cycle pulse when any det_out bit changes.

Function
REQ-014 SHALL hold per channel: thd_lev (signed MAG_W), bits_thd (unsigned CNT_W), on_cnt, off_cnt (CNT_W) and det.
REQ-015 SHALL ignore mag_valid, cfg_we and all state updates while clk_enable=0; all state held.
REQ-016 SHALL, on a sample with mag_in >= thd_lev[ch] (signed compare): on_cnt saturating-increment at bits_thd; off_cnt cleared.
REQ-017 SHALL, on a sample with mag_in < thd_lev[ch]: off_cnt saturating-increment at bits_thd; on_cnt cleared.
REQ-018 SHALL set det[ch] when on_cnt reaches bits_thd and clear it when off_cnt reaches bits_thd (symmetric hysteresis); det holds otherwise.
REQ-019 SHALL update det_out on the clock edge after the sample edge: latency is 1 cycle from the mag_valid edge at which the count reaches bits_thd.
REQ-020 SHALL force det[ch]=0 and freeze its counters while bits_thd[ch]=0 (channel disabled).
REQ-021 SHALL ignore samples with mag_ch >= N_CH.
REQ-022 SHALL map cfg_addr 2k to thd_lev[k] and 2k+1 to bits_thd[k] (low CNT_W bits of cfg_wdata); writes to addresses >= 2*N_CH ignored.
REQ-023 SHALL clear on_cnt and off_cnt of the written channel on any cfg write; det is unchanged.
REQ-024 SHALL, on a cfg write and sample for the same channel in the same cycle, apply the write and clear the counters; that sample is dropped.
REQ-025 SHALL assert det_chg for exactly one cycle, aligned with the det_out update.

Reset
REQ-026 SHALL, on reset low, asynchronously set thd_lev=DEF_THD, bits_thd=DEF_BITS, counters=0, det_out=0, det_chg=0 (det_irq=0 when present).
REQ-027 SHALL discard any sample or write in progress when reset is asserted mid-run, and SHALL resume from reset values on the first enabled edge after release.

Configuration
REQ-028 SHALL, with TONE_DET_IRQ_EN defined, add output det_irq (1) and input irq_clr (1); det_irq is sticky-set on any det_out 0->1 transition and cleared by irq_clr; set wins over a simultaneous clear.
REQ-029 SHALL, without TONE_DET_IRQ_EN, omit both ports and all related logic.

Structure
REQ-030 SHALL place DEF_THD/DEF_BITS defaults, the cfg address-map constants and the channel-state typedef in package tone_det_pkg.
REQ-031 SHALL instantiate N_CH copies of sub-module tone_det_chan (threshold, counters, hysteresis for one channel); the top decodes mag_ch and cfg_addr and ORs the change flags.

Verification
REQ-032 SHALL cover: reset defaults; ch0 fed 10 consecutive samples of 301 -> det_out[0]=1 exactly 1 cycle after the 10th sample, with det_chg pulsing once.
REQ-033 SHALL cover: after detection, 9 samples of 299 followed by 1 of 400 -> det_out[0] stays 1; then 10 samples of 0 -> det_out[0] falls, with det_chg pulsing.
REQ-034 SHALL cover: write addr 5 = 0 (bits_thd[2]=0), then feed ch2 samples of 1000 -> det_out[2] stays 0.
REQ-035 SHALL cover: same-cycle write of addr 0 = 50 and ch0 sample 301 at on_cnt=9 -> no detect, counters 0; 10 further samples of 60 -> detect.
REQ-036 SHALL cover: clk_enable=0 for 20 cycles with valid samples -> no state change; reset pulsed mid-run -> all outputs 0 immediately.
REQ-037 SHALL cover, with TONE_DET_IRQ_EN: detect on ch1 -> det_irq=1; detect rising and irq_clr in the same cycle -> det_irq stays 1.

Source files
------------

// File: rtl/tone_det_pkg.sv
// rtl/tone_det_pkg.sv - shared defaults, cfg address map and channel status type for tone_detect_bank
package tone_det_pkg;

    localparam int TD_DEF_THD  = 300;
    localparam int TD_DEF_BITS = 10;

    // cfg_addr = {channel, field}: field 0 is thd_lev, field 1 is bits_thd
    localparam int CFG_ADDR_W  = 5;
    localparam int CFG_CHAN_W  = CFG_ADDR_W - 1;
    localparam logic CFG_FIELD_THD  = 1'b0;
    localparam logic CFG_FIELD_BITS = 1'b1;

    typedef struct packed {
        logic det;
        logic chg;
    } chan_status_t;

    function automatic logic [CFG_CHAN_W-1:0] cfg_chan(input logic [CFG_ADDR_W-1:0] addr);
        return addr[CFG_ADDR_W-1:1];
    endfunction

    function automatic logic cfg_field(input logic [CFG_ADDR_W-1:0] addr);
        return addr[0];
    endfunction

endpackage

// File: rtl/tone_det_if.sv
// rtl/tone_det_if.sv - sample stream and register write bundle for tone_detect_bank
interface tone_det_if #(
    parameter int MAG_W = 16,
    parameter int CH_W  = 3
);
    logic signed [MAG_W-1:0] mag_in;
    logic [CH_W-1:0]         mag_ch;
    logic                    mag_valid;
    logic                    cfg_we;
    logic [4:0]              cfg_addr;
    logic [MAG_W-1:0]        cfg_wdata;

    modport master (output mag_in, mag_ch, mag_valid, cfg_we, cfg_addr, cfg_wdata);
    modport slave  (input  mag_in, mag_ch, mag_valid, cfg_we, cfg_addr, cfg_wdata);
endinterface

// File: rtl/tone_det_chan.sv
// rtl/tone_det_chan.sv - one tone channel: threshold, run-length counters, symmetric hysteresis
module tone_det_chan
    import tone_det_pkg::*;
#(
    parameter int MAG_W    = 16,
    parameter int CNT_W    = 8,
    parameter int DEF_THD  = TD_DEF_THD,
    parameter int DEF_BITS = TD_DEF_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_enable,
    input  logic                    sample,
    input  logic signed [MAG_W-1:0] mag_in,
    input  logic                    wr_thd,
    input  logic                    wr_bits,
    input  logic [MAG_W-1:0]        wdata,
    output chan_status_t            status
);

    logic signed [MAG_W-1:0] thd_lev;
    logic [CNT_W-1:0]        bits_thd;
    logic [CNT_W-1:0]        on_cnt;
    logic [CNT_W-1:0]        off_cnt;
    logic                    det;
    logic                    chg;
    logic                    det_next;
    logic                    disabled;

    assign disabled = (bits_thd == '0);

    // det follows the registered counts, so it lands one edge after the count saturates
    always_comb begin
        det_next = det;
        if (disabled)
            det_next = 1'b0;
        else if (on_cnt == bits_thd)
            det_next = 1'b1;
        else if (off_cnt == bits_thd)
            det_next = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            thd_lev  <= MAG_W'(DEF_THD);
            bits_thd <= CNT_W'(DEF_BITS);
            on_cnt   <= '0;
            off_cnt  <= '0;
            det      <= 1'b0;
            chg      <= 1'b0;
        end else if (clk_enable) begin
            det <= det_next;
            chg <= (det_next != det);
            if (wr_thd)
                thd_lev <= $signed(wdata);
            if (wr_bits)
                bits_thd <= wdata[CNT_W-1:0];
            // a write restarts the run counts and swallows any same-cycle sample
            if (wr_thd || wr_bits) begin
                on_cnt  <= '0;
                off_cnt <= '0;
            end else if (sample && !disabled) begin
                if (mag_in >= thd_lev) begin
                    on_cnt  <= (on_cnt >= bits_thd) ? bits_thd : on_cnt + CNT_W'(1);
                    off_cnt <= '0;
                end else begin
                    off_cnt <= (off_cnt >= bits_thd) ? bits_thd : off_cnt + CNT_W'(1);
                    on_cnt  <= '0;
                end
            end
        end else begin
            chg <= 1'b0;
        end
    end

    assign status = '{det: det, chg: chg};

endmodule

// File: rtl/tone_detect_bank.sv
// rtl/tone_detect_bank.sv - bank of tone channels with channel/cfg decode; TONE_DET_IRQ_EN adds det_irq/irq_clr
module tone_detect_bank
    import tone_det_pkg::*;
#(
    parameter int N_CH     = 6,
    parameter int MAG_W    = 16,
    parameter int CNT_W    = 8,
    parameter int DEF_THD  = TD_DEF_THD,
    parameter int DEF_BITS = TD_DEF_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_enable,
    tone_det_if.slave       bus,
`ifdef TONE_DET_IRQ_EN
    input  logic            irq_clr,
    output logic            det_irq,
`endif
    output logic [N_CH-1:0] det_out,
    output logic            det_chg
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    chan_status_t     status [N_CH];
    logic [N_CH-1:0]  chg_vec;

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        logic sample;
        logic wr_hit;

        // out-of-range channels and addresses simply never match a slot
        assign sample = bus.mag_valid && (bus.mag_ch == CH_W'(k));
        assign wr_hit = bus.cfg_we && (cfg_chan(bus.cfg_addr) == CFG_CHAN_W'(k));

        tone_det_chan #(
            .MAG_W    (MAG_W),
            .CNT_W    (CNT_W),
            .DEF_THD  (DEF_THD),
            .DEF_BITS (DEF_BITS)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .clk_enable (clk_enable),
            .sample     (sample),
            .mag_in     (bus.mag_in),
            .wr_thd     (wr_hit && (cfg_field(bus.cfg_addr) == CFG_FIELD_THD)),
            .wr_bits    (wr_hit && (cfg_field(bus.cfg_addr) == CFG_FIELD_BITS)),
            .wdata      (bus.cfg_wdata),
            .status     (status[k])
        );

        assign det_out[k] = status[k].det;
        assign chg_vec[k] = status[k].chg;
    end

    assign det_chg = |chg_vec;

`ifdef TONE_DET_IRQ_EN
    logic rise_any;

    // a changed bit that is now high is a 0->1 transition
    assign rise_any = |(chg_vec & det_out);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            det_irq <= 1'b0;
        else if (clk_enable) begin
            if (rise_any)
                det_irq <= 1'b1;
            else if (irq_clr)
                det_irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_tone_detect_bank.sv
// tb/tb_tone_detect_bank.sv - directed self-checking bench for tone_detect_bank
`timescale 1ns/1ps
module tb_tone_detect_bank;

    localparam int N_CH  = 6;
    localparam int MAG_W = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clk_enable = 1'b1;
    logic [N_CH-1:0] det_out;
    logic det_chg;
`ifdef TONE_DET_IRQ_EN
    logic irq_clr = 1'b0;
    logic det_irq;
`endif

    int tests_run = 0;
    int fails = 0;

    tone_det_if #(.MAG_W(MAG_W), .CH_W(3)) bus ();

    tone_detect_bank #(.N_CH(N_CH), .MAG_W(MAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .bus        (bus),
`ifdef TONE_DET_IRQ_EN
        .irq_clr    (irq_clr),
        .det_irq    (det_irq),
`endif
        .det_out    (det_out),
        .det_chg    (det_chg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.mag_valid = 1'b0;
        bus.cfg_we    = 1'b0;
    endtask

    task automatic feed(input int ch, input int val, input int n);
        for (int i = 0; i < n; i++) begin
            bus.mag_valid = 1'b1;
            bus.mag_ch    = 3'(ch);
            bus.mag_in    = 16'(val);
            step();
        end
        bus.mag_valid = 1'b0;
    endtask

    task automatic cfg_write(input int addr, input int data);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 5'(addr);
        bus.cfg_wdata = 16'(data);
        step();
        bus.cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle();
        bus.mag_ch = '0; bus.mag_in = '0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        reset = 1'b0;
        step();
        tests_run++;
        if (det_out !== 6'b0 || det_chg !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: actual det_out=%b det_chg=%b required 000000/0", det_out, det_chg);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_detect();
        feed(0, 301, 9);
        step();
        tests_run++;
        if (det_out !== 6'b0) begin
            fails++;
            $display("FAIL detect_9_samples: actual=%b required=000000", det_out);
        end
        feed(0, 301, 1);
        tests_run++;
        if (det_out[0] !== 1'b0) begin
            fails++;
            $display("FAIL detect_latency_early: actual=%b required=0", det_out[0]);
        end
        step();
        tests_run++;
        if (det_out !== 6'b000001 || det_chg !== 1'b1) begin
            fails++;
            $display("FAIL detect_rise: actual det_out=%b det_chg=%b required 000001/1", det_out, det_chg);
        end
        step();
        tests_run++;
        if (det_out !== 6'b000001 || det_chg !== 1'b0) begin
            fails++;
            $display("FAIL detect_chg_single: actual det_out=%b det_chg=%b required 000001/0", det_out, det_chg);
        end
    endtask

    task automatic test_hysteresis();
        int chg_seen;
        feed(0, 299, 9);
        feed(0, 400, 1);
        chg_seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (det_chg === 1'b1) chg_seen++;
        end
        tests_run++;
        if (det_out[0] !== 1'b1 || chg_seen != 0) begin
            fails++;
            $display("FAIL hyst_hold: actual det=%b chg_pulses=%0d required 1/0", det_out[0], chg_seen);
        end
        feed(0, 0, 10);
        tests_run++;
        if (det_out[0] !== 1'b1) begin
            fails++;
            $display("FAIL hyst_fall_early: actual=%b required=1", det_out[0]);
        end
        step();
        tests_run++;
        if (det_out[0] !== 1'b0 || det_chg !== 1'b1) begin
            fails++;
            $display("FAIL hyst_fall: actual det=%b chg=%b required 0/1", det_out[0], det_chg);
        end
        step();
    endtask

    task automatic test_disable();
        cfg_write(5, 0);
        feed(2, 1000, 12);
        step(); step();
        tests_run++;
        if (det_out[2] !== 1'b0) begin
            fails++;
            $display("FAIL disabled_chan: actual=%b required=0", det_out[2]);
        end
        feed(7, 1000, 12);
        feed(6, 1000, 12);
        step(); step();
        tests_run++;
        if (det_out !== 6'b0) begin
            fails++;
            $display("FAIL bad_chan_ignored: actual=%b required=000000", det_out);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        feed(0, 301, 9);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 5'd0;
        bus.cfg_wdata = 16'd50;
        bus.mag_valid = 1'b1;
        bus.mag_ch    = 3'd0;
        bus.mag_in    = 16'd301;
        step();
        idle();
        step(); step();
        tests_run++;
        if (det_out[0] !== 1'b0) begin
            fails++;
            $display("FAIL same_cycle_drop: actual=%b required=0", det_out[0]);
        end
        feed(0, 60, 9);
        step();
        tests_run++;
        if (det_out[0] !== 1'b0) begin
            fails++;
            $display("FAIL same_cycle_cleared: actual=%b required=0", det_out[0]);
        end
        feed(0, 60, 1);
        step();
        tests_run++;
        if (det_out[0] !== 1'b1) begin
            fails++;
            $display("FAIL same_cycle_new_thd: actual=%b required=1", det_out[0]);
        end
        step();
    endtask

    task automatic test_enable_and_reset();
        int chg_seen;
        clk_enable = 1'b0;
        chg_seen = 0;
        for (int i = 0; i < 20; i++) begin
            bus.mag_valid = 1'b1;
            bus.mag_ch    = (i % 2 == 0) ? 3'd1 : 3'd0;
            bus.mag_in    = (i % 2 == 0) ? 16'd1000 : 16'd0;
            bus.cfg_we    = (i == 5);
            bus.cfg_addr  = 5'd3;
            bus.cfg_wdata = 16'd1;
            step();
            if (det_chg === 1'b1) chg_seen++;
        end
        idle();
        tests_run++;
        if (det_out !== 6'b000001 || chg_seen != 0) begin
            fails++;
            $display("FAIL enable_hold: actual det_out=%b chg_pulses=%0d required 000001/0", det_out, chg_seen);
        end
        clk_enable = 1'b1;
        feed(1, 1000, 9);
        feed(0, 0, 9);
        step();
        tests_run++;
        if (det_out !== 6'b000001) begin
            fails++;
            $display("FAIL enable_no_advance: actual=%b required=000001", det_out);
        end
        feed(1, 1000, 1);
        step();
        tests_run++;
        if (det_out !== 6'b000011) begin
            fails++;
            $display("FAIL enable_resume: actual=%b required=000011", det_out);
        end
        #3;
        reset = 1'b0;
        #1;
        tests_run++;
        if (det_out !== 6'b0 || det_chg !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: actual det_out=%b det_chg=%b required 000000/0", det_out, det_chg);
        end
        step();
        reset = 1'b1;
        feed(0, 300, 9);
        step();
        tests_run++;
        if (det_out !== 6'b0) begin
            fails++;
            $display("FAIL reset_resume_early: actual=%b required=000000", det_out);
        end
        feed(0, 300, 1);
        step();
        tests_run++;
        if (det_out !== 6'b000001) begin
            fails++;
            $display("FAIL reset_resume_defaults: actual=%b required=000001", det_out);
        end
        step();
    endtask

`ifdef TONE_DET_IRQ_EN
    task automatic test_irq();
        do_reset();
        tests_run++;
        if (det_irq !== 1'b0) begin
            fails++;
            $display("FAIL irq_reset: actual=%b required=0", det_irq);
        end
        feed(1, 301, 10);
        step(); step();
        tests_run++;
        if (det_irq !== 1'b1) begin
            fails++;
            $display("FAIL irq_set: actual=%b required=1", det_irq);
        end
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        tests_run++;
        if (det_irq !== 1'b0) begin
            fails++;
            $display("FAIL irq_clear: actual=%b required=0", det_irq);
        end
        feed(0, 301, 10);
        step();
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        tests_run++;
        if (det_irq !== 1'b1) begin
            fails++;
            $display("FAIL irq_set_wins: actual=%b required=1", det_irq);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_detect();
        test_hysteresis();
        test_disable();
        test_same_cycle();
        test_enable_and_reset();
`ifdef TONE_DET_IRQ_EN
        test_irq();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
